// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The cache takes the slave modport; the CPU/memory environment takes the master modport.
interface icache_direct_mapped_if #(
    parameter int WORD_SIZE = 16
);
    // cpu_ready qualifies cpu_data in the cycle cpu_read is high; the CPU holds
    // cpu_address until it sees cpu_ready. mem_read stays high until the memory
    // answers with a one-cycle mem_ready carrying the whole line on mem_data.
    logic                   cpu_read;
    logic [WORD_SIZE-1:0]   cpu_address;
    logic [WORD_SIZE-1:0]   cpu_data;
    logic                   cpu_ready;
    logic                   invalidate;
    logic                   mem_read;
    logic [WORD_SIZE-1:0]   mem_address;
    logic [4*WORD_SIZE-1:0] mem_data;
    logic                   mem_ready;

    modport slave (
        input  cpu_read, cpu_address, invalidate, mem_data, mem_ready,
        output cpu_data, cpu_ready, mem_read, mem_address
    );

    modport master (
        output cpu_read, cpu_address, invalidate, mem_data, mem_ready,
        input  cpu_data, cpu_ready, mem_read, mem_address
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: combinational hits, 4-word line
// refill on a miss via an IDLE / MISS_WAIT / REFILL controller.
module icache_direct_mapped #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LINES = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    icache_direct_mapped_if.slave bus,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count,
    output logic [1:0]           o_dbg_state
);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = WORD_SIZE - IB - 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MISS_WAIT = 2'd1,
        S_REFILL    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_LINES-1:0]  r_valid;
    logic [TW-1:0]         r_tag  [NUM_LINES];
    logic [WORD_SIZE-1:0]  r_data [NUM_LINES][4];
    logic                  r_mem_read;
    logic [WORD_SIZE-1:0]  r_mem_address;
    logic [WORD_SIZE-1:0]  r_hit_count;
    logic [WORD_SIZE-1:0]  r_miss_count;

    logic [1:0]            w_offset;
    logic [IB-1:0]         w_index;
    logic [TW-1:0]         w_tag;
    logic [IB-1:0]         w_fill_index;
    logic [TW-1:0]         w_fill_tag;
    logic [IB-1:0]         w_rd_index;
    logic [WORD_SIZE-1:0]  w_word;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_fill;
    logic                  w_cpu_ready;

    assign w_offset     = bus.cpu_address[1:0];
    assign w_index      = bus.cpu_address[IB+1:2];
    assign w_tag        = bus.cpu_address[WORD_SIZE-1:IB+2];
    // The pending line's index and tag live in the latched request address.
    assign w_fill_index = r_mem_address[IB+1:2];
    assign w_fill_tag   = r_mem_address[WORD_SIZE-1:IB+2];
    assign w_rd_index   = (r_state == S_REFILL) ? w_fill_index : w_index;
    assign w_word       = r_data[w_rd_index][w_offset];

    always_comb begin
        w_next_state = r_state;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        w_cpu_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_read) begin
                    // A same-cycle invalidate turns a would-be hit into a miss.
                    if (r_valid[w_index] && (r_tag[w_index] == w_tag) && !bus.invalidate) begin
                        w_hit       = 1'b1;
                        w_cpu_ready = 1'b1;
                    end else begin
                        w_miss       = 1'b1;
                        w_next_state = S_MISS_WAIT;
                    end
                end
            end
            S_MISS_WAIT: begin
                if (bus.mem_ready) begin
                    w_fill       = 1'b1;
                    w_next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                w_cpu_ready  = bus.cpu_read;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_mem_read    <= 1'b0;
            r_mem_address <= '0;
            r_hit_count   <= '0;
            r_miss_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_hit)
                r_hit_count <= r_hit_count + WORD_SIZE'(1);
            if (w_miss) begin
                r_miss_count  <= r_miss_count + WORD_SIZE'(1);
                r_mem_read    <= 1'b1;
                r_mem_address <= {bus.cpu_address[WORD_SIZE-1:2], 2'b00};
            end
            if (w_fill)
                r_mem_read <= 1'b0;
            // Line being installed wins over a coincident invalidate.
            if (bus.invalidate)
                r_valid <= '0;
            if (w_fill)
                r_valid[w_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_fill) begin
            r_tag[w_fill_index] <= w_fill_tag;
            for (int k = 0; k < 4; k++)
                r_data[w_fill_index][k] <= bus.mem_data[k*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign bus.cpu_ready   = w_cpu_ready;
    assign bus.cpu_data    = w_cpu_ready ? w_word : '0;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_address = r_mem_address;
    assign hit_count       = r_hit_count;
    assign miss_count      = r_miss_count;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: a line-pattern memory model, fetch
// tasks, and a scoreboard queue of expected fetch words.
module tb_icache_direct_mapped;
    localparam int W = 16;

    logic         Clk;
    logic         Reset_N;
    logic [W-1:0] hit_count;
    logic [W-1:0] miss_count;
    logic [1:0]   o_dbg_state;

    icache_direct_mapped_if #(.WORD_SIZE(W)) bus ();

    icache_direct_mapped #(.WORD_SIZE(W), .NUM_LINES(8)) dut (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .bus         (bus),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    // Memory contents: word at address a is 0x4000 + a.
    function automatic logic [W-1:0] word_of(input logic [W-1:0] a);
        return 16'h4000 + a;
    endfunction

    function automatic logic [4*W-1:0] line_of(input logic [W-1:0] a);
        logic [W-1:0] base;
        base = {a[W-1:2], 2'b00};
        return {word_of(base + 16'd3), word_of(base + 16'd2), word_of(base + 16'd1), word_of(base)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed data %0h with no expected entry", tag, bus.cpu_data);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.cpu_data, e);
        end
    endtask

    // One fetch of address a. Misses are serviced with mem_ready in the lat-th
    // MISS_WAIT cycle; optional invalidate on the first or fill cycle, optional
    // cpu_read drop during the stall.
    task automatic fetch(input logic [W-1:0] a, input bit exp_hit, input int lat,
                         input bit inv_first, input bit inv_fill, input bit drop);
        logic [W-1:0] line_a;
        line_a = {a[W-1:2], 2'b00};
        if (!drop) exp_q.push_back(word_of(a));
        @(negedge Clk);
        bus.cpu_read    = 1'b1;
        bus.cpu_address = a;
        bus.invalidate  = inv_first;
        #1;
        if (exp_hit) begin
            check("hit_ready", bus.cpu_ready, 1);
            check("hit_no_mem_read", bus.mem_read, 0);
            pop_compare("hit_data");
        end else begin
            check("miss_ready", bus.cpu_ready, 0);
            check("miss_data", bus.cpu_data, 0);
            for (int i = 0; i < lat; i++) begin
                @(negedge Clk);
                if (drop) bus.cpu_read = 1'b0;
                bus.mem_ready  = (i == lat - 1);
                bus.invalidate = inv_fill && (i == lat - 1);
                bus.mem_data   = line_of(line_a);
                #1;
                check("wait_mem_read", bus.mem_read, 1);
                check("wait_mem_addr", bus.mem_address, line_a);
                check("wait_stall", bus.cpu_ready, 0);
            end
            @(negedge Clk);
            bus.mem_ready  = 1'b0;
            bus.invalidate = 1'b0;
            #1;
            check("refill_mem_read", bus.mem_read, 0);
            if (drop) begin
                check("drop_ready", bus.cpu_ready, 0);
                check("drop_data", bus.cpu_data, 0);
            end else begin
                check("refill_ready", bus.cpu_ready, 1);
                pop_compare("refill_data");
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge Clk);
        bus.cpu_read   = 1'b0;
        bus.invalidate = 1'b0;
        bus.mem_ready  = 1'b0;
        #1;
    endtask

    task automatic check_counts(input string tag, input int hits, input int misses);
        check({tag, "_hits"}, hit_count, hits);
        check({tag, "_misses"}, miss_count, misses);
    endtask

    initial begin
        Reset_N         = 1'b0;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = '0;
        bus.invalidate  = 1'b0;
        bus.mem_data    = '0;
        bus.mem_ready   = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_ready", bus.cpu_ready, 0);
        check("rst_data", bus.cpu_data, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_addr", bus.mem_address, 0);
        check_counts("rst", 0, 0);
        check("rst_state", o_dbg_state, 0);
        bus.cpu_read = 1'b0;
        @(negedge Clk);
        Reset_N = 1'b1;

        // Cold miss, then sequential hits in the same line
        fetch(16'h0000, 0, 3, 0, 0, 0);
        check_counts("cold", 0, 1);
        fetch(16'h0001, 1, 0, 0, 0, 0);
        fetch(16'h0002, 1, 0, 0, 0, 0);
        fetch(16'h0003, 1, 0, 0, 0, 0);
        idle_cycle();
        check_counts("seq_hits", 3, 1);

        // Conflict on index 0
        fetch(16'h0020, 0, 2, 0, 0, 0);
        fetch(16'h0000, 0, 1, 0, 0, 0);
        idle_cycle();
        check_counts("conflict", 3, 3);

        // Invalidate pulse, then re-read of the cached line
        @(negedge Clk);
        bus.invalidate = 1'b1;
        fetch(16'h0001, 0, 2, 0, 0, 0);
        // Invalidate in the same cycle as a would-be hit
        fetch(16'h0002, 0, 1, 1, 0, 0);
        idle_cycle();
        check_counts("invalidate", 3, 5);

        // Invalidate coinciding with a fill: only the installed line survives
        fetch(16'h0004, 0, 1, 0, 0, 0);
        fetch(16'h0021, 0, 2, 0, 1, 0);
        fetch(16'h0022, 1, 0, 0, 0, 0);
        fetch(16'h0005, 0, 1, 0, 0, 0);
        idle_cycle();
        check_counts("inv_fill", 4, 8);

        // Reset in the middle of a fill
        @(negedge Clk);
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 16'h0010;
        @(negedge Clk);
        #1;
        check("midfill_mem_read", bus.mem_read, 1);
        #2;
        Reset_N = 1'b0;
        #1;
        check("async_mem_read", bus.mem_read, 0);
        check("async_state", o_dbg_state, 0);
        check_counts("async", 0, 0);
        @(negedge Clk);
        Reset_N      = 1'b1;
        bus.cpu_read = 1'b0;
        @(negedge Clk);
        bus.mem_ready = 1'b1;
        bus.mem_data  = line_of(16'h0010);
        #1;
        check("stray_ready_mem_read", bus.mem_read, 0);
        idle_cycle();
        check("stray_ready_state", o_dbg_state, 0);
        fetch(16'h0010, 0, 1, 0, 0, 0);
        fetch(16'h0000, 0, 2, 0, 0, 0);

        // cpu_read dropped during the stall
        fetch(16'h0040, 0, 2, 0, 0, 1);
        fetch(16'h0041, 1, 0, 0, 0, 0);
        idle_cycle();
        check_counts("drop", 1, 3);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
